// File: rtl/pipe_stage_skid.sv
// Purpose : valid/ready pipeline register with a 2-entry skid buffer (pc, pc+1, sideband, payload).
// Latency : 1 cycle from accepted beat to out_valid; 1 beat/cycle sustained with out_ready high.
// Backpressure: in_ready is a pure decode of the state register (low only when both entries are full).
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   in_valid/in_ready, in_*               upstream handshake and beat fields
//   out_valid/out_ready, out_*            downstream handshake and head beat fields (0 when empty)
//   stall, flush                          hazard-unit controls (stall = hold, flush = clear to bubble)
//   occupancy                             entries held (0..2)
//   stall_cnt, bubble_cnt                 statistics, present only when PIPE_STATS_EN is defined
//
// Build option: define PIPE_STATS_EN to add the saturating stall/bubble counters;
// otherwise both counter outputs are tied to zero.

module pipe_stage_skid #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int SIDE_W = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_pcplus1,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pcplus1,
  output logic [SIDE_W-1:0] out_side,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pcplus1;
    logic [SIDE_W-1:0] side;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  beat_t  head_q, head_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  beat_t  out_beat;
  logic   push;
  logic   pop;

  assign in_beat = '{data: in_data, pc: in_pc, pcplus1: in_pcplus1, side: in_side};

  // Both handshake outputs decode the state register only, so there is no
  // combinational path from out_ready/stall/flush back to in_ready.
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~stall;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush beats any push or pop in the same cycle; the incoming beat is dropped.
      state_d = S_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d = S_ONE;
            head_d  = in_beat;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_d = in_beat;
          end else if (push) begin
            state_d = S_TWO;
            skid_d  = in_beat;
          end else if (pop) begin
            state_d = S_EMPTY;
            head_d  = '0;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d = S_ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Head is already zero whenever the stage is empty; the gate keeps the
  // NOP-bubble guarantee independent of how head got there.
  assign out_beat    = out_valid ? head_q : '0;
  assign out_data    = out_beat.data;
  assign out_pc      = out_beat.pc;
  assign out_pcplus1 = out_beat.pcplus1;
  assign out_side    = out_beat.side;

  assign occupancy = (state_q == S_TWO) ? 2'd2 :
                     (state_q == S_ONE) ? 2'd1 : 2'd0;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Counters saturate and ignore flush; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid && !pop && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Purpose : self-checking bench for pipe_stage_skid (directed table, corner sequences, random vs queue model).
// Latency : checks outputs 1 time unit after each rising edge.
// Backpressure: model accepts a beat only while fewer than two are held.

module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  in_pc;
  logic [7:0]  in_pcplus1;
  logic [0:0]  in_side;
  logic        out_valid;
  logic        out_ready;
  logic        stall;
  logic        flush;
  logic [15:0] out_data;
  logic [7:0]  out_pc;
  logic [7:0]  out_pcplus1;
  logic [0:0]  out_side;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  // Second instance with narrow counters to observe saturation.
  logic        d2_in_ready;
  logic        d2_out_valid;
  logic [15:0] d2_out_data;
  logic [7:0]  d2_out_pc;
  logic [7:0]  d2_out_pcplus1;
  logic [0:0]  d2_out_side;
  logic [1:0]  d2_occupancy;
  logic [1:0]  d2_stall_cnt;
  logic [1:0]  d2_bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(16), .PC_W(8), .SIDE_W(1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pc(in_pc), .in_pcplus1(in_pcplus1), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready), .stall(stall), .flush(flush),
    .out_data(out_data), .out_pc(out_pc), .out_pcplus1(out_pcplus1), .out_side(out_side),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.DATA_W(16), .PC_W(8), .SIDE_W(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_data(in_data), .in_pc(in_pc), .in_pcplus1(in_pcplus1), .in_side(in_side),
    .out_valid(d2_out_valid), .out_ready(out_ready), .stall(stall), .flush(flush),
    .out_data(d2_out_data), .out_pc(d2_out_pc), .out_pcplus1(d2_out_pcplus1), .out_side(d2_out_side),
    .occupancy(d2_occupancy), .stall_cnt(d2_stall_cnt), .bubble_cnt(d2_bubble_cnt)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {valid, data, pc, pcplus1, side, occupancy, in_ready}
  function automatic logic [36:0] pack(input logic v, input logic [15:0] d, input logic [7:0] pc,
                                       input logic [7:0] p1, input logic s, input logic [1:0] occ,
                                       input logic rdy);
    return {v, d, pc, p1, s, occ, rdy};
  endfunction

  logic [36:0] dut_v;
  logic [36:0] d2_v;
  assign dut_v = {out_valid, out_data, out_pc, out_pcplus1, out_side, occupancy, in_ready};
  assign d2_v  = {d2_out_valid, d2_out_data, d2_out_pc, d2_out_pcplus1, d2_out_side, d2_occupancy, d2_in_ready};

  // ---------------- reference model: a FIFO of at most two beats ----------------
  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  pc;
    logic [7:0]  pcplus1;
    logic        side;
  } mbeat_t;

  mbeat_t mq[$];
  longint m_stall  = 0;
  longint m_bubble = 0;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall  = 0;
    m_bubble = 0;
  endtask

  // Advance one clock: evaluate the rules on the pre-edge state, then let the DUT clock.
  task automatic cycle();
    bit     acc;
    bit     take;
    mbeat_t b;
    acc  = in_valid && (mq.size() < 2);
    take = (mq.size() > 0) && out_ready && !stall;
    b    = '{data: in_data, pc: in_pc, pcplus1: in_pcplus1, side: in_side[0]};
    if (reset_n) begin
      if (mq.size() > 0 && !take && !flush) m_stall++;
      if (mq.size() == 0) m_bubble++;
      if (flush) begin
        mq.delete();
      end else begin
        if (take) void'(mq.pop_front());
        if (acc) mq.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] model_vec();
    if (mq.size() > 0)
      return pack(1'b1, mq[0].data, mq[0].pc, mq[0].pcplus1, mq[0].side, 2'(mq.size()), mq.size() < 2);
    return pack(1'b0, 16'h0, 8'h0, 8'h0, 1'b0, 2'd0, 1'b1);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_vec"}, 64'(dut_v), 64'(model_vec()));
    chk({tag, "_vec_w2"}, 64'(d2_v), 64'(model_vec()));
`ifdef PIPE_STATS_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(sat(m_stall, 16)));
    chk({tag, "_bubble_cnt"}, 64'(bubble_cnt), 64'(sat(m_bubble, 16)));
    chk({tag, "_stall_cnt_w2"}, 64'(d2_stall_cnt), 64'(sat(m_stall, 2)));
    chk({tag, "_bubble_cnt_w2"}, 64'(d2_bubble_cnt), 64'(sat(m_bubble, 2)));
`else
    chk({tag, "_stall_cnt_off"}, 64'(stall_cnt), 64'd0);
    chk({tag, "_bubble_cnt_off"}, 64'(bubble_cnt), 64'd0);
`endif
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [7:0] pc,
                       input logic [7:0] p1, input logic s, input logic ordy,
                       input logic stl, input logic fl);
    in_valid   = v;
    in_data    = d;
    in_pc      = pc;
    in_pcplus1 = p1;
    in_side    = s;
    out_ready  = ordy;
    stall      = stl;
    flush      = fl;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        iv;
    logic [15:0] d;
    logic [7:0]  pc;
    logic        ordy;
    logic        stl;
    logic        fl;
    logic        ev;    // expected after the edge
    logic [15:0] ed;
    logic [7:0]  epc;
    logic [1:0]  eocc;
    logic        erdy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, input logic [15:0] d, input logic [7:0] pc,
                     input logic ordy, input logic stl, input logic fl,
                     input logic ev, input logic [15:0] ed, input logic [7:0] epc,
                     input logic [1:0] eocc, input logic erdy);
    vec_t r;
    r = '{iv: iv, d: d, pc: pc, ordy: ordy, stl: stl, fl: fl,
          ev: ev, ed: ed, epc: epc, eocc: eocc, erdy: erdy};
    vq.push_back(r);
  endtask

  initial begin
    logic [7:0]  p1;
    logic [7:0]  ep1;
    logic [36:0] ev;

    drive(1'b0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    model_reset();

    //   iv  data     pc     ordy stl fl | ev  data     pc    occ  rdy
    // stream three beats at full rate
    add(1, 16'h1234, 8'h10, 1, 0, 0,  1, 16'h1234, 8'h10, 2'd1, 1);
    add(1, 16'h5678, 8'h11, 1, 0, 0,  1, 16'h5678, 8'h11, 2'd1, 1);
    add(1, 16'h9ABC, 8'h12, 1, 0, 0,  1, 16'h9ABC, 8'h12, 2'd1, 1);
    add(0, 16'h0000, 8'h00, 1, 0, 0,  0, 16'h0000, 8'h00, 2'd0, 1);
    // fill the skid entry, refuse a third beat, then drain in order
    add(1, 16'hAAAA, 8'h30, 0, 0, 0,  1, 16'hAAAA, 8'h30, 2'd1, 1);
    add(1, 16'hBBBB, 8'h31, 0, 0, 0,  1, 16'hAAAA, 8'h30, 2'd2, 0);
    add(1, 16'hCCCC, 8'h32, 0, 0, 0,  1, 16'hAAAA, 8'h30, 2'd2, 0);
    add(0, 16'h0000, 8'h00, 1, 0, 0,  1, 16'hBBBB, 8'h31, 2'd1, 1);
    add(0, 16'h0000, 8'h00, 1, 0, 0,  0, 16'h0000, 8'h00, 2'd0, 1);
    // flush while full, with push and stall also high
    add(1, 16'hD001, 8'h40, 0, 0, 0,  1, 16'hD001, 8'h40, 2'd1, 1);
    add(1, 16'hD002, 8'h41, 0, 0, 0,  1, 16'hD001, 8'h40, 2'd2, 0);
    add(1, 16'hD003, 8'h42, 1, 1, 1,  0, 16'h0000, 8'h00, 2'd0, 1);
    add(0, 16'h0000, 8'h00, 1, 0, 0,  0, 16'h0000, 8'h00, 2'd0, 1);
    // flush with one entry, overriding a simultaneous push and pop
    add(1, 16'hE001, 8'h50, 0, 0, 0,  1, 16'hE001, 8'h50, 2'd1, 1);
    add(1, 16'hE002, 8'h51, 1, 0, 1,  0, 16'h0000, 8'h00, 2'd0, 1);
    add(0, 16'h0000, 8'h00, 1, 0, 0,  0, 16'h0000, 8'h00, 2'd0, 1);

    // reset state while reset_n is low
    #12;
    chk("reset_vec", 64'(dut_v), 64'(pack(1'b0, 16'h0, 8'h0, 8'h0, 1'b0, 2'd0, 1'b1)));
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_bubble_cnt", 64'(bubble_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // table
    foreach (vq[i]) begin
      p1 = vq[i].pc + 8'd1;
      drive(vq[i].iv, vq[i].d, vq[i].pc, p1, vq[i].pc[0], vq[i].ordy, vq[i].stl, vq[i].fl);
      cycle();
      ep1 = vq[i].ev ? (vq[i].epc + 8'd1) : 8'd0;
      ev  = pack(vq[i].ev, vq[i].ed, vq[i].epc, ep1, vq[i].ev & vq[i].epc[0], vq[i].eocc, vq[i].erdy);
      chk($sformatf("table_%0d", i), 64'(dut_v), 64'(ev));
    end

    // stall hold: head stays put for three stalled cycles, pops when stall drops
    drive(1'b1, 16'hC0DE, 8'h20, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("stall_hold_%0d", k), 64'(dut_v),
          64'(pack(1'b1, 16'hC0DE, 8'h20, 8'h21, 1'b1, 2'd1, 1'b1)));
    end
    stall = 1'b0;
    cycle();
    chk("stall_release_pop", 64'(dut_v), 64'(pack(1'b0, 16'h0, 8'h0, 8'h0, 1'b0, 2'd0, 1'b1)));

    // async reset between edges with two entries held
    drive(1'b1, 16'hF001, 8'h70, 8'h71, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'hF002, 8'h71, 8'h72, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("pre_async_full", 64'(dut_v), 64'(pack(1'b1, 16'hF001, 8'h70, 8'h71, 1'b0, 2'd2, 1'b0)));
    in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_vec", 64'(dut_v), 64'(pack(1'b0, 16'h0, 8'h0, 8'h0, 1'b0, 2'd0, 1'b1)));
    chk("async_reset_stall_cnt", 64'(stall_cnt), 64'd0);

    // statistics: 4 cycles without a valid head, then stalled head
    drive(1'b0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) cycle();
    drive(1'b1, 16'h5A5A, 8'h60, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
`ifdef PIPE_STATS_EN
    chk("stats_bubble_4", 64'(bubble_cnt), 64'd4);
    chk("stats_stall_5", 64'(stall_cnt), 64'd5);
`else
    chk("stats_off_bubble", 64'(bubble_cnt), 64'd0);
    chk("stats_off_stall", 64'(stall_cnt), 64'd0);
`endif
    cycle();
`ifdef PIPE_STATS_EN
    chk("stats_stall_6", 64'(stall_cnt), 64'd6);
    chk("stats_stall_sat_w2", 64'(d2_stall_cnt), 64'd3);
`else
    chk("stats_off_stall_w2", 64'(d2_stall_cnt), 64'd0);
`endif
    check_model("stats_model");

    // randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 4) != 0, 16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom % 3) != 0, ($urandom % 8) == 0, ($urandom % 32) == 0);
      cycle();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register; the next generation of the fixed-width IF/ID-style latch.
- Carries a DATA_W payload plus a PC_W program counter and a SIDE_W sideband field (e.g. matrix-mult flag) between two pipeline stages.
- Uses valid/ready handshake with a 2-entry skid buffer, so in_ready is purely registered and full throughput is sustained.
- Keeps stall/flush control compatible with the hazard unit: stall = hold, flush = insert zero bubble.

Parameters:
- DATA_W, 16, payload width (instruction word).
- PC_W, 8, program counter width (pc and pcplus1 each).
- SIDE_W, 1, sideband flag width.
- CNT_W, 16, statistics counter width (used only with PIPE_STATS_EN).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept a beat; registered.
- in_data  in  DATA_W  upstream payload.
- in_pc  in  PC_W  upstream pc.
- in_pcplus1  in  PC_W  upstream pc+1.
- in_side  in  SIDE_W  upstream sideband.
- out_valid  out  1  stage holds a valid beat.
- out_ready  in  1  downstream accepts.
- stall  in  1  hazard-unit stall; when 1, treated as out_ready=0.
- flush  in  1  hazard-unit flush; synchronous, clears stage.
- out_data  out  DATA_W  head payload.
- out_pc  out  PC_W  head pc.
- out_pcplus1  out  PC_W  head pc+1.
- out_side  out  SIDE_W  head sideband.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and no pop (PIPE_STATS_EN).
- bubble_cnt  out  CNT_W  cycles with out_valid=0 (PIPE_STATS_EN).

Behaviour:
- Reset is asynchronous, active-low: reset_n=0 forces state EMPTY, all out_* fields 0, out_valid=0, in_ready=1, occupancy=0, counters 0.
- Definitions: push = in_valid & in_ready. pop = out_valid & out_ready & ~stall.
- Storage is a head register and a skid register. Outputs always come from head.
- EMPTY (occ 0):
  - push -> ONE; head<=in.
- ONE (occ 1):
  - push & pop -> ONE; head<=in.
  - push & ~pop -> TWO; skid<=in.
  - ~push & pop -> EMPTY; head<=0.
  - Otherwise hold.
- TWO (occ 2):
  - in_ready=0.
  - pop -> ONE; head<=skid, skid<=0.
  - Otherwise hold.
- in_ready = (state != TWO), decoded from the state register only. There is no combinational path from out_ready, stall or flush.
- out_valid = (state != EMPTY).
- When out_valid=0, all out_* fields read 0 (NOP bubble).
- Latency: 1 cycle from push to out_valid in EMPTY. Throughput is 1 beat/cycle with out_ready held high.
- Flush: at the next edge, state goes to EMPTY, head and skid clear to 0, and in_ready becomes 1.
  - Flush overrides push and pop in the same cycle; the incoming beat is dropped and counts as not accepted by the stage.
  - Upstream must not retry that beat; upstream is flushed concurrently by the hazard unit.
- Stall and flush both high: flush wins.
- Payload is never modified. pc and pcplus1 are stored verbatim, with no arithmetic.
- No beat is lost or duplicated except by flush. Order is FIFO.
- reset_n asserted mid-transfer discards both entries immediately; no pop is reported.

Optional Feature:
- PIPE_STATS_EN defined:
  - stall_cnt increments each cycle with out_valid & ~pop & ~flush.
  - bubble_cnt increments each cycle with ~out_valid.
  - Both counters saturate at 2^CNT_W-1, are cleared by reset only, and are unaffected by flush.
- PIPE_STATS_EN undefined: stall_cnt and bubble_cnt are tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset then stream: release reset_n; push data 0x1234,0x5678,0x9ABC with pc 0x10,0x11,0x12 and out_ready=1 -> out_valid from cycle after first push; same three beats in order, one per cycle; in_ready stays 1.
- Skid fill: push 0xAAAA then 0xBBBB with out_ready=0 -> occupancy 2, in_ready=0; then out_ready=1 -> 0xAAAA popped, then 0xBBBB; in_ready returns to 1 after first pop.
- Stall hold: stage holding 0xC0DE, pc 0x20, side 1; stall=1 for 3 cycles with out_ready=1 -> outputs unchanged for 3 cycles; pop on first cycle stall=0.
- Flush priority: occupancy 2, assert flush with in_valid=1 and stall=1 -> next cycle occupancy 0, out_valid=0, out_data/out_pc/out_pcplus1/out_side all 0, in_ready=1; flushed-in beat never appears.
- Async reset mid-operation: occupancy 2, drop reset_n between edges -> outputs 0 and in_ready=1 immediately, without waiting for a clock edge.
- Stats (PIPE_STATS_EN): 4 idle cycles then 5 stalled cycles with valid head -> bubble_cnt=4, stall_cnt=5. With CNT_W=2, stall 6 cycles -> stall_cnt=3 (saturated).
